// File: rtl/grad_pkg.sv
// rtl/grad_pkg.sv - shared state encoding, default geometry width and configuration legality check
package grad_pkg;

  localparam int DIM_W = 13;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    RUN      = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  // A frame needs at least one full kernel footprint in both directions.
  function automatic logic cfg_legal(input int w, input int h, input int k);
    return (w >= k) && (h >= k);
  endfunction

endpackage

// File: rtl/grad_pos_counter.sv
// rtl/grad_pos_counter.sv - column/row position counter with end-of-line and last-pixel flags
module grad_pos_counter #(
  parameter int DIM_W = 13
) (
  input  logic             i_clk,
  input  logic             i_aresetn,
  input  logic             i_sof,
  input  logic             i_step,
  input  logic [DIM_W-1:0] i_width,
  input  logic [DIM_W-1:0] i_height,
  output logic             o_eol,
  output logic             o_last
);

  logic [DIM_W-1:0] col;
  logic [DIM_W-1:0] row;

  assign o_eol  = (col == i_width - DIM_W'(1));
  assign o_last = o_eol && (row == i_height - DIM_W'(1));

  // SOF beat is pixel (0,0) itself, so the next expected pixel is column 1.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      col <= '0;
      row <= '0;
    end else if (i_sof) begin
      col <= DIM_W'(1);
      row <= '0;
    end else if (i_step) begin
      if (o_eol) begin
        col <= '0;
        row <= row + DIM_W'(1);
      end else begin
        col <= col + DIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/gradient_frame_ctrl.sv
// rtl/gradient_frame_ctrl.sv - frame sequencer for the gradient pipeline; GRAD_CTRL_TIMEOUT_EN adds a drain watchdog
module gradient_frame_ctrl #(
  parameter int DIM_W       = grad_pkg::DIM_W,
  parameter int KERNEL_SIZE = 5,
  parameter int FCNT_W      = 16
`ifdef GRAD_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_W = 20
`endif
) (
  input  logic              i_clk,
  input  logic              i_aresetn,
  input  logic              i_enable,
  input  logic [DIM_W-1:0]  i_cfg_width,
  input  logic [DIM_W-1:0]  i_cfg_height,
  input  logic              i_err_clr,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tuser,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  input  logic              i_m_tvalid,
  input  logic              i_m_tlast,
  output logic [DIM_W-1:0]  o_img_width,
  output logic [DIM_W-1:0]  o_img_height,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [FCNT_W-1:0] o_frame_count,
  output logic              o_err_cfg,
  output logic              o_err_early_eol,
  output logic              o_err_missing_eol,
  output logic              o_err_sof_mid,
  output logic              o_err_timeout
);

  import grad_pkg::*;

  state_t           state, state_nxt;
  logic             acc, sof_acc, run_acc, m_eol_beat;
  logic             pos_eol, pos_last, last_acc;
  logic             cfg_ok, latch_cfg, cfg_err;
  logic             frame_end, timeout_hit, boundary;
  logic [DIM_W-1:0] drain_cnt, drain_cnt_sum;
  logic             ev_early, ev_missing, ev_sof;

  assign acc           = s_axis_tvalid & s_axis_tready;
  assign sof_acc       = (state == WAIT_SOF) & acc & s_axis_tuser;
  assign run_acc       = (state == RUN) & acc;
  assign last_acc      = run_acc & pos_last;
  assign m_eol_beat    = i_m_tvalid & i_m_tlast;
  assign drain_cnt_sum = drain_cnt + DIM_W'(m_eol_beat);
  assign frame_end     = (state == DRAIN) && (drain_cnt_sum == o_img_height);
  assign boundary      = frame_end | timeout_hit;
  assign cfg_ok        = cfg_legal(int'(i_cfg_width), int'(i_cfg_height), KERNEL_SIZE);
  assign o_busy        = (state == RUN) || (state == DRAIN);

  assign ev_early   = run_acc & s_axis_tlast & ~pos_eol;
  assign ev_missing = run_acc & pos_eol & ~s_axis_tlast;
  assign ev_sof     = run_acc & s_axis_tuser;

  grad_pos_counter #(.DIM_W(DIM_W)) u_in_pos (
    .i_clk     (i_clk),
    .i_aresetn (i_aresetn),
    .i_sof     (sof_acc),
    .i_step    (run_acc),
    .i_width   (o_img_width),
    .i_height  (o_img_height),
    .o_eol     (pos_eol),
    .o_last    (pos_last)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state decode; geometry is only (re)sampled at frame boundaries.
  always_comb begin
    state_nxt = state;
    latch_cfg = 1'b0;
    cfg_err   = 1'b0;
    case (state)
      IDLE: begin
        if (i_enable) begin
          if (cfg_ok) begin
            latch_cfg = 1'b1;
            state_nxt = WAIT_SOF;
          end else begin
            cfg_err = 1'b1;
          end
        end
      end
      WAIT_SOF: begin
        if (!i_enable)    state_nxt = IDLE;
        else if (sof_acc) state_nxt = RUN;
      end
      RUN: begin
        if (last_acc) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (boundary) begin
          if (!i_enable) begin
            state_nxt = IDLE;
          end else if (cfg_ok) begin
            latch_cfg = 1'b1;
            state_nxt = WAIT_SOF;
          end else begin
            cfg_err   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ready follows the next state so it lines up with the state register.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) s_axis_tready <= 1'b0;
    else            s_axis_tready <= (state_nxt == WAIT_SOF) || (state_nxt == RUN);
  end

  // Latched geometry seen by the datapath.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      o_img_width  <= '0;
      o_img_height <= '0;
    end else if (latch_cfg) begin
      o_img_width  <= i_cfg_width;
      o_img_height <= i_cfg_height;
    end
  end

  // Output end-of-line counter; an output tlast on the last-pixel accept cycle already counts.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn)                          drain_cnt <= '0;
    else if ((state == DRAIN) || last_acc)   drain_cnt <= drain_cnt_sum;
    else if (state != RUN)                   drain_cnt <= '0;
  end

  // Frame completion pulse and wrapping frame counter.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      o_frame_done  <= 1'b0;
      o_frame_count <= '0;
    end else begin
      o_frame_done <= frame_end;
      if (frame_end) o_frame_count <= o_frame_count + FCNT_W'(1);
    end
  end

  // Sticky error flags; a new event beats a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      o_err_cfg         <= 1'b0;
      o_err_early_eol   <= 1'b0;
      o_err_missing_eol <= 1'b0;
      o_err_sof_mid     <= 1'b0;
    end else begin
      o_err_cfg         <= cfg_err    | (o_err_cfg         & ~i_err_clr);
      o_err_early_eol   <= ev_early   | (o_err_early_eol   & ~i_err_clr);
      o_err_missing_eol <= ev_missing | (o_err_missing_eol & ~i_err_clr);
      o_err_sof_mid     <= ev_sof     | (o_err_sof_mid     & ~i_err_clr);
    end
  end

`ifdef GRAD_CTRL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] to_cnt;

  assign timeout_hit = (state == DRAIN) && !i_m_tvalid && (&to_cnt) && !frame_end;

  // Drain watchdog: restarts on any output activity, idle outside DRAIN.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn)                        to_cnt <= '0;
    else if ((state != DRAIN) || i_m_tvalid) to_cnt <= '0;
    else                                   to_cnt <= to_cnt + TIMEOUT_W'(1);
  end

  // Sticky timeout flag.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) o_err_timeout <= 1'b0;
    else            o_err_timeout <= timeout_hit | (o_err_timeout & ~i_err_clr);
  end
`else
  assign timeout_hit   = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_gradient_frame_ctrl.sv
// tb/tb_gradient_frame_ctrl.sv - randomized self-checking bench for gradient_frame_ctrl
module tb_gradient_frame_ctrl;

  localparam int DIM_W  = 13;
  localparam int FCNT_W = 16;

  logic              i_clk = 1'b0;
  logic              i_aresetn = 1'b0;
  logic              i_enable = 1'b0;
  logic [DIM_W-1:0]  i_cfg_width = '0;
  logic [DIM_W-1:0]  i_cfg_height = '0;
  logic              i_err_clr = 1'b0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tuser = 1'b0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tready;
  logic              i_m_tvalid = 1'b0;
  logic              i_m_tlast = 1'b0;
  logic [DIM_W-1:0]  o_img_width, o_img_height;
  logic              o_busy, o_frame_done;
  logic [FCNT_W-1:0] o_frame_count;
  logic              o_err_cfg, o_err_early_eol, o_err_missing_eol, o_err_sof_mid, o_err_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int done_pulses = 0;
  int exp_count = 0;
  bit exp_early = 0, exp_missing = 0, exp_sof = 0, exp_cfg = 0;

  gradient_frame_ctrl #(
    .DIM_W(DIM_W), .KERNEL_SIZE(5), .FCNT_W(FCNT_W)
`ifdef GRAD_CTRL_TIMEOUT_EN
    , .TIMEOUT_W(4)
`endif
  ) dut (
    .i_clk(i_clk), .i_aresetn(i_aresetn), .i_enable(i_enable),
    .i_cfg_width(i_cfg_width), .i_cfg_height(i_cfg_height), .i_err_clr(i_err_clr),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready), .i_m_tvalid(i_m_tvalid), .i_m_tlast(i_m_tlast),
    .o_img_width(o_img_width), .o_img_height(o_img_height), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_frame_count(o_frame_count), .o_err_cfg(o_err_cfg),
    .o_err_early_eol(o_err_early_eol), .o_err_missing_eol(o_err_missing_eol),
    .o_err_sof_mid(o_err_sof_mid), .o_err_timeout(o_err_timeout)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_frame_done === 1'b1) done_pulses++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_flags(input string tag);
    check_eq({tag, "_err_cfg"},     o_err_cfg,         exp_cfg);
    check_eq({tag, "_err_early"},   o_err_early_eol,   exp_early);
    check_eq({tag, "_err_missing"}, o_err_missing_eol, exp_missing);
    check_eq({tag, "_err_sof_mid"}, o_err_sof_mid,     exp_sof);
    check_eq({tag, "_err_timeout"}, o_err_timeout,     0);
  endtask

  task automatic pulse_clr();
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    exp_cfg = 0; exp_early = 0; exp_missing = 0; exp_sof = 0;
  endtask

  task automatic send_beat(input bit u, input bit l);
    int guard = 0;
    s_axis_tvalid = 1'b1; s_axis_tuser = u; s_axis_tlast = l;
    while (s_axis_tready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check_eq("beat_ready_timeout", guard, 0);
    tick();
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(2, 0)) begin
        i_m_tvalid = 1'(($urandom_range(1, 0)));
        i_m_tlast  = 1'b0;
        tick();
      end
      i_m_tvalid = 1'b1; i_m_tlast = 1'b1;
      tick();
      i_m_tvalid = 1'b0; i_m_tlast = 1'b0;
    end
  endtask

  // inj_mode: 0 clean, 1 tlast inverted at inj_pos, 2 tuser set at inj_pos (inj_pos >= 1)
  task automatic run_frame(input int w, input int h, input int garbage, input int inj_mode,
                           input int inj_pos, input bit same_cycle, input int next_w,
                           input int next_h, input bit gaps, input bit drop_en);
    int start_done = done_pulses;
    int n_out;
    for (int g = 0; g < garbage; g++) send_beat(1'b0, 1'(($urandom_range(1, 0))));
    for (int k = 0; k < w * h; k++) begin
      bit u = (k == 0);
      bit l = ((k % w) == (w - 1));
      if (inj_mode == 1 && k == inj_pos) l = !l;
      if (inj_mode == 2 && k == inj_pos) u = 1'b1;
      if (k > 0 && u) exp_sof = 1;
      if (k > 0 && l && (k % w) != (w - 1)) exp_early = 1;
      if (k > 0 && !l && (k % w) == (w - 1)) exp_missing = 1;
      if (gaps) repeat ($urandom_range(1, 0)) tick();
      if (k == (w * h) / 2) begin
        i_cfg_width = DIM_W'(next_w); i_cfg_height = DIM_W'(next_h);
      end
      if (k == w * h - 1 && same_cycle) begin
        i_m_tvalid = 1'b1; i_m_tlast = 1'b1;
      end
      send_beat(u, l);
      i_m_tvalid = 1'b0; i_m_tlast = 1'b0;
    end
    check_eq("drain_tready", s_axis_tready, 0);
    check_eq("drain_busy", o_busy, 1);
    check_eq("hold_width", o_img_width, w);
    check_eq("hold_height", o_img_height, h);
    if (drop_en) i_enable = 1'b0;
    n_out = same_cycle ? h - 1 : h;
    drain(n_out - 1);
    check_eq("no_early_done", done_pulses - start_done, 0);
    i_m_tvalid = 1'b1; i_m_tlast = 1'b1;
    tick();
    i_m_tvalid = 1'b0; i_m_tlast = 1'b0;
    exp_count++;
    check_eq("done_latency", o_frame_done, 1);
    check_eq("tready_after_done", s_axis_tready, i_enable);
    check_eq("frame_count", o_frame_count, exp_count % (1 << FCNT_W));
    check_eq("next_width", o_img_width, i_enable ? next_w : w);
    tick();
    check_eq("done_single_pulse", done_pulses - start_done, 1);
    check_eq("busy_after_done", o_busy, 0);
    check_flags("frame");
  endtask

  initial begin
    int cur_w, cur_h, nw, nh, im;
    repeat (3) tick();
    check_eq("rst_tready", s_axis_tready, 0);
    check_eq("rst_width", o_img_width, 0);
    check_eq("rst_height", o_img_height, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_done", o_frame_done, 0);
    check_eq("rst_count", o_frame_count, 0);
    check_flags("rst");
    i_aresetn = 1'b1;
    tick();

    // Illegal configurations on each axis; clear is overridden by a same-cycle set.
    i_cfg_width = 13'd4; i_cfg_height = 13'd6; i_enable = 1'b1;
    repeat (3) tick();
    exp_cfg = 1;
    check_eq("illegal_w_tready", s_axis_tready, 0);
    check_eq("illegal_w_busy", o_busy, 0);
    check_flags("illegal_w");
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    check_eq("clr_vs_set", o_err_cfg, 1);
    i_enable = 1'b0;
    tick();
    pulse_clr();
    check_flags("cfg_cleared");
    i_cfg_width = 13'd5; i_cfg_height = 13'd4; i_enable = 1'b1;
    tick();
    i_enable = 1'b0;
    exp_cfg = 1;
    tick();
    check_eq("illegal_h_tready", s_axis_tready, 0);
    check_flags("illegal_h");
    pulse_clr();

    // Basic frame with leading garbage.
    i_cfg_width = 13'd8; i_cfg_height = 13'd6; i_enable = 1'b1;
    tick();
    check_eq("enable_tready_lat", s_axis_tready, 1);
    check_eq("latched_width", o_img_width, 8);
    check_eq("latched_height", o_img_height, 6);
    run_frame(8, 6, 3, 0, 0, 1'b0, 8, 6, 1'b0, 1'b0);

    // Early end-of-line at column 5 of row 2, then clear.
    run_frame(8, 6, 0, 1, 2 * 8 + 5, 1'b0, 8, 6, 1'b0, 1'b0);
    pulse_clr();
    check_flags("early_cleared");

    // Geometry change in RUN and disable in DRAIN.
    run_frame(8, 6, 0, 0, 0, 1'b1, 16, 6, 1'b1, 1'b1);
    repeat (2) tick();
    check_eq("idle_tready", s_axis_tready, 0);

    // Randomized frames with chained geometry.
    cur_w = 16; cur_h = 6;
    i_enable = 1'b1;
    tick();
    for (int f = 0; f < 16; f++) begin
      nw = $urandom_range(9, 5);
      nh = $urandom_range(9, 5);
      im = $urandom_range(2, 0);
      if ($urandom_range(2, 0) == 0) pulse_clr();
      run_frame(cur_w, cur_h, $urandom_range(3, 0), im, $urandom_range(cur_w * cur_h - 1, 1),
                1'($urandom_range(1, 0)), nw, nh, 1'($urandom_range(1, 0)), 1'b0);
      cur_w = nw; cur_h = nh;
    end

`ifdef GRAD_CTRL_TIMEOUT_EN
    begin
      int n = 0;
      int cnt_before = exp_count;
      pulse_clr();
      for (int k = 0; k < cur_w * cur_h; k++) send_beat(k == 0, (k % cur_w) == cur_w - 1);
      while (o_err_timeout !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      check_eq("timeout_cycles", n, 16);
      check_eq("timeout_count", o_frame_count, cnt_before % (1 << FCNT_W));
      check_eq("timeout_tready", s_axis_tready, 1);
    end
`endif

    // Asynchronous reset in the middle of a frame.
    send_beat(1'b1, 1'b0);
    send_beat(1'b0, 1'b0);
    #2 i_aresetn = 1'b0;
    #1;
    check_eq("async_rst_tready", s_axis_tready, 0);
    check_eq("async_rst_width", o_img_width, 0);
    check_eq("async_rst_count", o_frame_count, 0);
    check_eq("async_rst_busy", o_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
